// File: rtl/serial_full_subtractor_if.sv
// Start/done handshake bundle for the bit-serial subtractor.
// The master issues operands; the slave returns the registered result.
interface serial_full_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_full_subtractor.sv
// Bit-serial a - b - bin: one full-subtractor cell plus a borrow flop,
// LSB first, WIDTH SHIFT cycles per operation, result held until next completion.
module serial_full_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_full_subtractor_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sd_r;
    logic             br_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

    logic             d_s;
    logic             br_next_s;
    logic [WIDTH:0]   sd_cat_s;
    logic [WIDTH-1:0] sd_next_s;

    function automatic logic fs_diff(input logic x, input logic y, input logic bi);
        return x ^ y ^ bi;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
        return (~x & y) | (~(x ^ y) & bi);
    endfunction

    // Full-subtractor cell on the current LSBs and next partial-result word.
    always_comb begin
        d_s       = fs_diff(sa_r[0], sb_r[0], br_r);
        br_next_s = fs_borrow(sa_r[0], sb_r[0], br_r);
        // Shifting the concatenation keeps the insert valid even when WIDTH is 1.
        sd_cat_s  = {d_s, sd_r} >> 1'b1;
        sd_next_s = sd_cat_s[WIDTH-1:0];
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sa_r    <= {WIDTH{1'b0}};
            sb_r    <= {WIDTH{1'b0}};
            sd_r    <= {WIDTH{1'b0}};
            br_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            diff_r  <= {WIDTH{1'b0}};
            bout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        sa_r    <= bus.a;
                        sb_r    <= bus.b;
                        br_r    <= bus.bin;
                        cnt_r   <= {CNT_W{1'b0}};
                        sd_r    <= {WIDTH{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    sa_r  <= sa_r >> 1'b1;
                    sb_r  <= sb_r >> 1'b1;
                    br_r  <= br_next_s;
                    sd_r  <= sd_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        diff_r  <= sd_next_s;
                        bout_r  <= br_next_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed-vector bench for serial_full_subtractor (WIDTH=4); expected results
// go into a scoreboard queue and a monitor compares them on every done pulse.
module tb_serial_full_subtractor;
    localparam int W = 4;

    logic clk;
    logic rst;
    serial_full_subtractor_if #(.WIDTH(W)) bus ();

    serial_full_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int done_cnt = 0;
    int cyc      = 0;
    logic [W:0] sb_q[$];
    int done_cyc[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                chk("result_diff_bout", {bus.diff, bus.bout}, sb_q.pop_front());
            end
        end
    end

    // Drive at a negedge; start is held for exactly one cycle.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic bi, input logic [W-1:0] ed, input logic eb);
        bus.start = 1'b1; bus.a = av; bus.b = bv; bus.bin = bi;
        sb_q.push_back({ed, eb});
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_within_bound", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int busy_n;
        int lat;
        rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;

        // Reset with random inputs toggling
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus.start = 1'($urandom_range(0, 1));
            bus.a     = W'($urandom_range(0, 15));
            bus.b     = W'($urandom_range(0, 15));
            bus.bin   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_diff", {28'd0, bus.diff}, 32'd0);
        chk("reset_bout", {31'd0, bus.bout}, 32'd0);
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // 5 - 3: busy count and done timing
        bus.start = 1'b1; bus.a = 4'd5; bus.b = 4'd3; bus.bin = 1'b0;
        sb_q.push_back({4'h2, 1'b0});
        busy_n = 0; lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy === 1'b1) busy_n++;
            if (bus.done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("busy_cycles", busy_n, 32'd4);
        chk("done_negedges_after_drive", lat, 32'd5);
        @(negedge clk);
        chk("done_single_cycle", {31'd0, bus.done}, 32'd0);

        start_op(4'd7, 4'd7, 1'b0, 4'h0, 1'b0); wait_done(20); @(negedge clk);
        start_op(4'd3, 4'd5, 1'b0, 4'hE, 1'b1); wait_done(20); @(negedge clk);
        start_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1); wait_done(20); @(negedge clk);

        // Re-start while busy must be ignored; held result must not move
        start_op(4'd9, 4'd4, 1'b0, 4'h5, 1'b0);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd8;
        chk("hold_diff_a", {28'd0, bus.diff}, 32'hF);
        chk("hold_bout_a", {31'd0, bus.bout}, 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        chk("hold_diff_b", {28'd0, bus.diff}, 32'hF);
        chk("hold_bout_b", {31'd0, bus.bout}, 32'd1);
        wait_done(20);
        @(negedge clk);

        // Reset at the second SHIFT cycle aborts with no done
        start_op(4'd12, 4'd3, 1'b0, 4'h9, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        chk("abort_diff", {28'd0, bus.diff}, 32'd0);
        chk("abort_bout", {31'd0, bus.bout}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        repeat (8) @(negedge clk);
        start_op(4'd12, 4'd3, 1'b0, 4'h9, 1'b0); wait_done(20); @(negedge clk);

        // Back-to-back with start held high
        bus.start = 1'b1; bus.a = 4'd15; bus.b = 4'd1; bus.bin = 1'b0;
        sb_q.push_back({4'hE, 1'b0});
        wait_done(20);
        bus.a = 4'd2; bus.b = 4'd2;
        sb_q.push_back({4'h0, 1'b0});
        wait_done(20);
        bus.start = 1'b0;
        if (done_cyc.size() >= 2)
            chk("b2b_done_spacing", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 32'd6);
        else
            chk("b2b_done_count", done_cyc.size(), 32'd2);

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        chk("total_done_pulses", done_cnt, 32'd8);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
